scoreboard_warp: RTL and testbench

- Per-warp scoreboard sitting beside IBuffer_warp. It tracks up to 4 in-flight instructions that have been issued from the IBuffer read pointer.
- Raises Dependent on RAW/WAW hazards against the next candidate instruction.
- Hands out ScbIDs on grant and frees entries on writeback clears and replay-complete notifications.
- Drives Full/Empty status back to the IBuffer. Empty gates Exit requests.

---
 rtl/scoreboard_warp.sv | 151 +++++++++++++++
 tb/tb_scoreboard_warp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_warp.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_warp
// Purpose  : Per-warp scoreboard beside IBuffer_warp. Tracks up to 2**ID_W
//            in-flight instructions, flags RAW/WAW hazards against the next
//            IBuffer candidate, allocates ScbIDs on grant and frees entries on
//            writeback clears and replay-complete notifications.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            Src1/Src2/Dst_IB_Scb (+Valid) - candidate register IDs
//            RP_Grt_IB_Scb                 - allocate entry for candidate
//            Replayable_IB_Scb             - candidate is LW/SW
//            Replay_Complete_*_IB_Scb      - replay finished for an entry
//            Clear_*_WB_Scb                - writeback finished for an entry
//            Full/Empty_Scb_IB             - occupancy status
//            Dependent_Scb_IB              - candidate hazards a valid entry
//            ScbID_Scb_IB                  - ID the next allocation will use
// Options  : SCB_MEM_ORDER_EN - when defined, a memory candidate is also
//            dependent on any valid memory entry whose replay is incomplete.
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard_warp #(
  parameter int REG_W = 5,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Src1_IB_Scb,
  input  logic [REG_W-1:0] Src2_IB_Scb,
  input  logic [REG_W-1:0] Dst_IB_Scb,
  input  logic             Src1_Valid_IB_Scb,
  input  logic             Src2_Valid_IB_Scb,
  input  logic             Dst_Valid_IB_Scb,
  input  logic             RP_Grt_IB_Scb,
  input  logic             Replayable_IB_Scb,
  input  logic             Replay_Complete_IB_Scb,
  input  logic [ID_W-1:0]  Replay_Complete_ScbID_IB_Scb,
  input  logic             Replay_Complete_SW_LWbar_IB_Scb,
  input  logic             Clear_Valid_WB_Scb,
  input  logic [ID_W-1:0]  Clear_ScbID_WB_Scb,
  output logic             Full_Scb_IB,
  output logic             Empty_Scb_IB,
  output logic             Dependent_Scb_IB,
  output logic [ID_W-1:0]  ScbID_Scb_IB
);

  localparam int N = 2 ** ID_W;

  // Per-entry state: valid, destination, dest-valid, replayable,
  // replay-complete, writeback-done.
  logic [N-1:0]     v_q,  v_d;
  logic [N-1:0]     dv_q, dv_d;
  logic [N-1:0]     r_q,  r_d;
  logic [N-1:0]     c_q,  c_d;
  logic [N-1:0]     w_q,  w_d;
  logic [REG_W-1:0] d_q [N];
  logic [REG_W-1:0] d_d [N];

  logic [ID_W-1:0]  free_id;
  logic             dep;

  // Status derives from registered valid bits only.
  assign Full_Scb_IB  = &v_q;
  assign Empty_Scb_IB = ~|v_q;
  assign ScbID_Scb_IB = free_id;
  assign Dependent_Scb_IB = dep;

  // Lowest-index free entry; scanning downward leaves the lowest one last.
  always_comb begin
    free_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!v_q[i]) free_id = ID_W'(i);
    end
  end

  // Hazard detection against registered entries; no bypass of this
  // cycle's frees, and independent of the grant to avoid a loop.
  always_comb begin
    dep = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v_q[i] && dv_q[i]) begin
        if (Src1_Valid_IB_Scb && (Src1_IB_Scb == d_q[i])) dep = 1'b1;
        if (Src2_Valid_IB_Scb && (Src2_IB_Scb == d_q[i])) dep = 1'b1;
        if (Dst_Valid_IB_Scb  && (Dst_IB_Scb  == d_q[i])) dep = 1'b1;
      end
`ifdef SCB_MEM_ORDER_EN
      if (Replayable_IB_Scb && v_q[i] && r_q[i] && !c_q[i]) dep = 1'b1;
`endif
    end
  end

  always_comb begin
    v_d  = v_q;
    dv_d = dv_q;
    r_d  = r_q;
    c_d  = c_q;
    w_d  = w_q;
    for (int i = 0; i < N; i++) d_d[i] = d_q[i];

    // Writeback clear: free if replay already done, else remember it.
    if (Clear_Valid_WB_Scb && v_q[Clear_ScbID_WB_Scb]) begin
      if (c_q[Clear_ScbID_WB_Scb]) v_d[Clear_ScbID_WB_Scb] = 1'b0;
      else                         w_d[Clear_ScbID_WB_Scb] = 1'b1;
    end

    // Replay complete: SW never writes back; LW frees once its writeback
    // has been seen, including one arriving in this same cycle.
    if (Replay_Complete_IB_Scb && v_q[Replay_Complete_ScbID_IB_Scb]
        && r_q[Replay_Complete_ScbID_IB_Scb]) begin
      if (Replay_Complete_SW_LWbar_IB_Scb) begin
        v_d[Replay_Complete_ScbID_IB_Scb] = 1'b0;
      end else if (w_q[Replay_Complete_ScbID_IB_Scb] ||
                   (Clear_Valid_WB_Scb &&
                    (Clear_ScbID_WB_Scb == Replay_Complete_ScbID_IB_Scb))) begin
        v_d[Replay_Complete_ScbID_IB_Scb] = 1'b0;
      end else begin
        c_d[Replay_Complete_ScbID_IB_Scb] = 1'b1;
      end
    end

    // Allocation targets an entry that is invalid in registered state,
    // so it never collides with the clears above.
    if (RP_Grt_IB_Scb && !Full_Scb_IB) begin
      v_d[free_id]  = 1'b1;
      d_d[free_id]  = Dst_IB_Scb;
      dv_d[free_id] = Dst_Valid_IB_Scb;
      r_d[free_id]  = Replayable_IB_Scb;
      c_d[free_id]  = !Replayable_IB_Scb;
      w_d[free_id]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      dv_q <= '0;
      r_q  <= '0;
      c_q  <= '0;
      w_q  <= '0;
      for (int i = 0; i < N; i++) d_q[i] <= '0;
    end else begin
      v_q  <= v_d;
      dv_q <= dv_d;
      r_q  <= r_d;
      c_q  <= c_d;
      w_q  <= w_d;
      for (int i = 0; i < N; i++) d_q[i] <= d_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_warp.sv
`default_nettype none
// ============================================================================
// Module   : tb_scoreboard_warp
// Purpose  : Self-checking bench for scoreboard_warp using a table of
//            per-cycle inputs and hand-computed expected outputs, plus a
//            hand-written mid-operation reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scoreboard_warp;

  localparam int REG_W = 5;
  localparam int ID_W  = 2;

`ifdef SCB_MEM_ORDER_EN
  localparam logic MEM_DEP = 1'b1;
`else
  localparam logic MEM_DEP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] src1, src2, dst;
  logic             s1v, s2v, dstv;
  logic             grt, repl;
  logic             rc, rcsw;
  logic [ID_W-1:0]  rcid;
  logic             clr;
  logic [ID_W-1:0]  clrid;
  logic             full, empty, dep;
  logic [ID_W-1:0]  scbid;

  always #5 clk = ~clk;

  scoreboard_warp #(.REG_W(REG_W), .ID_W(ID_W)) dut (
    .clk                             (clk),
    .rst                             (rst),
    .Src1_IB_Scb                     (src1),
    .Src2_IB_Scb                     (src2),
    .Dst_IB_Scb                      (dst),
    .Src1_Valid_IB_Scb               (s1v),
    .Src2_Valid_IB_Scb               (s2v),
    .Dst_Valid_IB_Scb                (dstv),
    .RP_Grt_IB_Scb                   (grt),
    .Replayable_IB_Scb               (repl),
    .Replay_Complete_IB_Scb          (rc),
    .Replay_Complete_ScbID_IB_Scb    (rcid),
    .Replay_Complete_SW_LWbar_IB_Scb (rcsw),
    .Clear_Valid_WB_Scb              (clr),
    .Clear_ScbID_WB_Scb              (clrid),
    .Full_Scb_IB                     (full),
    .Empty_Scb_IB                    (empty),
    .Dependent_Scb_IB                (dep),
    .ScbID_Scb_IB                    (scbid)
  );

  typedef struct {
    logic             grt;
    logic             repl;
    logic [REG_W-1:0] dst;
    logic             dstv;
    logic [REG_W-1:0] s1;
    logic             s1v;
    logic [REG_W-1:0] s2;
    logic             s2v;
    logic             rc;
    logic [ID_W-1:0]  rcid;
    logic             rcsw;
    logic             clr;
    logic [ID_W-1:0]  clrid;
    logic             ef;
    logic             ee;
    logic             ed;
    logic [ID_W-1:0]  eid;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic v(input logic g, input logic rp, input int d, input logic dv,
                   input int a, input logic av, input int b, input logic bv,
                   input logic c, input int cid, input logic csw,
                   input logic cl, input int clid,
                   input logic ef, input logic ee, input logic ed, input int eid);
    vec_t t;
    t.grt = g;  t.repl = rp; t.dst = REG_W'(d); t.dstv = dv;
    t.s1 = REG_W'(a); t.s1v = av; t.s2 = REG_W'(b); t.s2v = bv;
    t.rc = c; t.rcid = ID_W'(cid); t.rcsw = csw;
    t.clr = cl; t.clrid = ID_W'(clid);
    t.ef = ef; t.ee = ee; t.ed = ed; t.eid = ID_W'(eid);
    vq.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    grt = t.grt; repl = t.repl; dst = t.dst; dstv = t.dstv;
    src1 = t.s1; s1v = t.s1v; src2 = t.s2; s2v = t.s2v;
    rc = t.rc; rcid = t.rcid; rcsw = t.rcsw;
    clr = t.clr; clrid = t.clrid;
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic chk_all(input int step, input vec_t t);
    chk("Full",      step, 32'(full),  32'(t.ef));
    chk("Empty",     step, 32'(empty), 32'(t.ee));
    chk("Dependent", step, 32'(dep),   32'(t.ed));
    chk("ScbID",     step, 32'(scbid), 32'(t.eid));
  endtask

  initial begin
    vec_t idle;
    // grt rp dst dv s1 s1v s2 s2v rc rcid sw clr clid | F E D id
    v(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,  0,1,0,0);  // 0 reset state
    v(1,0,1,1, 0,0,0,0, 0,0,0, 0,0,  0,1,0,0);  // 1 ADD r1
    v(1,0,2,1, 0,0,0,0, 0,0,0, 0,0,  0,0,0,1);  // 2 ADD r2
    v(1,0,3,1, 0,0,0,0, 0,0,0, 0,0,  0,0,0,2);  // 3 ADD r3
    v(1,0,4,1, 0,0,0,0, 0,0,0, 0,0,  0,0,0,3);  // 4 ADD r4
    v(1,0,5,1, 0,0,0,0, 0,0,0, 0,0,  1,0,0,0);  // 5 grant while full
    v(0,0,0,0, 0,0,3,1, 0,0,0, 0,0,  1,0,1,0);  // 6 src2=r3 RAW
    v(0,0,0,0, 0,0,3,1, 0,0,0, 1,2,  1,0,1,0);  // 7 clear id2, no bypass
    v(0,0,0,0, 0,0,3,1, 0,0,0, 0,0,  0,0,0,2);  // 8 freed
    v(0,0,0,0, 1,1,0,0, 0,0,0, 0,0,  0,0,1,2);  // 9 src1=r1 RAW
    v(0,0,4,1, 0,0,0,0, 0,0,0, 0,0,  0,0,1,2);  // 10 dst=r4 WAW
    v(0,0,4,0, 4,0,0,0, 0,0,0, 0,0,  0,0,0,2);  // 11 valids low
    v(0,0,0,0, 0,0,0,0, 0,0,0, 1,0,  0,0,0,2);  // 12 clear id0
    v(0,0,0,0, 0,0,0,0, 0,0,0, 1,1,  0,0,0,0);  // 13 clear id1
    v(0,0,0,0, 0,0,0,0, 0,0,0, 1,3,  0,0,0,0);  // 14 clear id3
    v(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,  0,1,0,0);  // 15 empty
    v(1,1,0,0, 0,0,0,0, 0,0,0, 0,0,  0,1,0,0);  // 16 SW grant id0
    v(0,0,0,0, 0,0,0,0, 1,0,1, 0,0,  0,0,0,1);  // 17 replay SW id0
    v(1,0,0,1, 0,0,0,0, 0,0,0, 0,0,  0,1,0,0);  // 18 ADD r0 id0
    v(1,1,7,1, 0,1,0,0, 0,0,0, 0,0,  0,0,1,1);  // 19 LW r7 id1, src1=r0
    v(0,0,0,0, 0,0,0,0, 0,0,0, 1,1,  0,0,0,2);  // 20 WB id1 first
    v(0,0,0,0, 7,1,0,0, 0,0,0, 0,0,  0,0,1,2);  // 21 still valid
    v(0,0,0,0, 0,0,0,0, 1,1,0, 0,0,  0,0,0,2);  // 22 replay LW id1
    v(0,0,0,0, 7,1,0,0, 0,0,0, 0,0,  0,0,0,1);  // 23 freed
    v(1,1,7,1, 0,0,0,0, 0,0,0, 0,0,  0,0,0,1);  // 24 LW r7 id1
    v(0,0,0,0, 0,0,0,0, 1,1,0, 0,0,  0,0,0,2);  // 25 replay first
    v(0,0,0,0, 7,1,0,0, 0,0,0, 0,0,  0,0,1,2);  // 26 still valid
    v(0,0,0,0, 0,0,0,0, 0,0,0, 1,1,  0,0,0,2);  // 27 WB id1
    v(0,0,0,0, 7,1,0,0, 0,0,0, 0,0,  0,0,0,1);  // 28 freed
    v(1,1,7,1, 0,0,0,0, 0,0,0, 0,0,  0,0,0,1);  // 29 LW r7 id1
    v(0,0,0,0, 0,0,0,0, 1,1,0, 1,1,  0,0,0,2);  // 30 replay+WB together
    v(0,0,0,0, 7,1,0,0, 0,0,0, 0,0,  0,0,0,1);  // 31 freed
    v(0,0,0,0, 0,0,0,0, 1,0,1, 0,0,  0,0,0,1);  // 32 replay on R=0 entry
    v(0,0,0,0, 0,1,0,0, 0,0,0, 0,0,  0,0,1,1);  // 33 entry0 kept
    v(1,1,8,1, 0,0,0,0, 0,0,0, 0,0,  0,0,0,1);  // 34 LW r8 id1
    v(0,1,0,0, 9,1,10,1, 0,0,0, 0,0, 0,0,MEM_DEP,2); // 35 SW cand, no overlap
    v(0,0,0,0, 0,0,0,0, 0,0,0, 1,3,  0,0,0,2);  // 36 clear invalid id3
    v(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,  0,0,0,2);  // 37 unchanged

    idle = vq[0];
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      drive(vq[i]);
      @(negedge clk);
      chk_all(i, vq[i]);
    end

    // Mid-operation reset with a pending clear: entries 0 and 1 are valid.
    @(posedge clk);
    #1;
    drive(idle);
    rst = 1'b1;
    clr = 1'b1; clrid = 2'd0;
    @(negedge clk);
    chk("pre_rst_empty", 100, 32'(empty), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(idle);
    src1 = 5'd0; s1v = 1'b1;
    @(negedge clk);
    chk("rst_empty", 101, 32'(empty), 32'd1);
    chk("rst_full",  101, 32'(full),  32'd0);
    chk("rst_dep",   101, 32'(dep),   32'd0);
    chk("rst_id",    101, 32'(scbid), 32'd0);

    // Refill after reset: allocation restarts at 0 and ends Full.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      drive(idle);
      grt = 1'b1; dst = REG_W'(10 + k); dstv = 1'b1;
      @(negedge clk);
      chk("refill_id", 102 + k, 32'(scbid), 32'(k));
    end
    @(posedge clk);
    #1;
    drive(idle);
    @(negedge clk);
    chk("refill_full", 106, 32'(full), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
